data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the MEM-stage data access interface.
- Accepts one load/store request from the pipeline and performs it on an internal word-organised RAM with configurable wait states.
- Returns read data or store completion through a valid/ready response handshake.
- Byte lanes, sign/zero extension and address range checks are all done here, so the MEM stage issues raw funct3 and address.

Parameters:
- DATA_BASE, 32'h10010000, byte address of word 0 of the RAM.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
- WAIT_STATES, 2, extra cycles between acceptance and response; allowed range 0..15.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V load/store funct3.
- req_address  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  pipeline accepts the response.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_error  output  1  access faulted; no memory change.

Behaviour:
- Reset (synchronous, active-high, on a clock edge with reset=1):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, wait counter=0.
  - RAM contents are not cleared.
  - Reset in any state aborts the transaction. A store not yet committed is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch write, funct3, address and wdata.
  - If WAIT_STATES=0: go to RESP.
  - Otherwise: counter<=WAIT_STATES-1, go to WAIT.
- WAIT:
  - req_ready=0.
  - If counter=0: perform the access and go to RESP.
  - Otherwise: decrement the counter.
  - With WAIT_STATES=0 the access is performed on the IDLE->RESP edge.
- RESP:
  - req_ready=0, resp_valid=1.
  - Outputs stay stable until resp_ready=1.
  - When resp_ready=1: resp_valid<=0 and go to IDLE on the next edge.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Latency: request accepted at edge N -> resp_valid first high after edge N+1+WAIT_STATES.
- Address decode:
  - offset = req_address - DATA_BASE (32-bit unsigned).
  - Index = offset[31:2].
  - In range iff offset < 4*DEPTH_WORDS. Out of range -> resp_error=1, rdata=0, no write.
  - Wrap-around below DATA_BASE produces a large offset and is therefore out of range.
- Loads (byte lane = addr[1:0], half lane = addr[1]):
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half.
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
  - 011, 110, 111: error.
- Stores:
  - 000 sb: write byte lane only.
  - 001 sh: write half lane only.
  - 010 sw: write all 4 lanes.
  - Any other funct3: error, no write.
  - Unselected lanes are unchanged (read-modify-write within one cycle, or byte enables).
  - Store response: resp_rdata=0, resp_error=0.
- Error responses still use the full latency and the handshake.
- Read-after-write: a load accepted after a store's response returns the stored value.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - lh, lhu, sh with addr[0]=1 -> resp_error=1.
  - lw, sw with addr[1:0]!=0 -> resp_error=1.
  - Faulting accesses return rdata=0 and do not write.
- Undefined:
  - No misalignment error.
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - The access is performed at the truncated aligned address.

Test Plan:
- Reset, then sw 32'hDEADBEEF at 32'h10010004 with WAIT_STATES=2 -> resp_valid after accept+3 edges, error=0. Then lw at the same address -> rdata=32'hDEADBEEF.
- sb 8'h80 at 32'h10010005 over word 32'hDEADBEEF -> word becomes 32'hDEAD80EF. lb at 0x..05 -> 32'hFFFFFF80; lbu -> 32'h00000080; lhu at 0x..06 -> 32'h0000DEAD.
- lw at 32'h1000FFFC and at DATA_BASE+4*DEPTH_WORDS -> resp_error=1, rdata=0. sw to the same addresses leaves RAM unchanged, confirmed by readback.
- Hold resp_ready=0 for 5 cycles: resp_valid and rdata stay stable and req_ready=0 throughout. Raise resp_ready -> resp_valid=0 next edge, req_ready=1.
- Assert reset during WAIT of an sw 32'h12345678 to 0x..08 -> outputs return to reset values next edge, and a later lw at 0x..08 returns the old value.
- sh at 32'h10010001: with DMEM_MISALIGN_TRAP_EN -> resp_error=1, no write. Without it -> the write lands on half 0 of word 0.

Source files
------------

// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one load/store, performs it on an internal word RAM after
// WAIT_STATES cycles, and returns the result over a valid/ready handshake.
// Optional misalignment trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module data_memory_responder #(
  parameter logic [31:0] DATA_BASE   = 32'h10010000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned IW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT   = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS_INIT = (WAIT_STATES == 0) ? '0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  wait_cnt;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] address_q, wdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        do_access;
  logic        cur_write;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_address, cur_wdata;
  logic [31:0] offset, word, load_data;
  logic [IW-1:0] idx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        in_range, funct_ok, misalign, access_error;

  // With zero wait states the access happens on the accept edge, so use the live request.
  always_comb begin
    if (state == IDLE) begin
      cur_write   = req_write;
      cur_funct3  = req_funct3;
      cur_address = req_address;
      cur_wdata   = req_wdata;
    end else begin
      cur_write   = write_q;
      cur_funct3  = funct3_q;
      cur_address = address_q;
      cur_wdata   = wdata_q;
    end
  end

  always_comb begin
    offset   = cur_address - DATA_BASE;
    in_range = offset < LIMIT;
    idx      = offset[IW+1:2];
    word     = mem[idx];
    case (cur_address[1:0])
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = cur_address[1] ? word[31:16] : word[15:0];

    funct_ok  = 1'b1;
    load_data = '0;
    if (cur_write) begin
      funct_ok = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010);
    end else begin
      case (cur_funct3)
        3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
        3'b010:  load_data = word;
        3'b100:  load_data = {24'd0, byte_sel};
        3'b101:  load_data = {16'd0, half_sel};
        default: funct_ok  = 1'b0;
      endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    case (cur_funct3)
      3'b001, 3'b101: misalign = cur_address[0];
      3'b010:         misalign = |cur_address[1:0];
      default:        misalign = 1'b0;
    endcase
`else
    misalign = 1'b0;
`endif

    access_error = !in_range || !funct_ok || misalign;
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            do_access  = 1'b1;
            next_state = RESP;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == '0) begin
          do_access  = 1'b1;
          next_state = RESP;
        end
      end
      RESP: begin
        if (resp_valid && resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // resp_valid rises one edge after entering RESP, giving accept-to-valid of WAIT_STATES+1 edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        write_q   <= req_write;
        funct3_q  <= req_funct3;
        address_q <= req_address;
        wdata_q   <= req_wdata;
        wait_cnt  <= WS_INIT;
      end
      if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
      if (do_access) begin
        resp_rdata <= (cur_write || access_error) ? '0 : load_data;
        resp_error <= access_error;
      end
      if (state == RESP) begin
        if (!resp_valid)     resp_valid <= 1'b1;
        else if (resp_ready) resp_valid <= 1'b0;
      end
    end
  end

  // RAM is never cleared; a reset on the commit edge discards the pending store.
  always_ff @(posedge clock) begin
    if (!reset && do_access && cur_write && !access_error) begin
      case (cur_funct3)
        3'b000: begin
          case (cur_address[1:0])
            2'd0:    mem[idx][7:0]   <= cur_wdata[7:0];
            2'd1:    mem[idx][15:8]  <= cur_wdata[7:0];
            2'd2:    mem[idx][23:16] <= cur_wdata[7:0];
            default: mem[idx][31:24] <= cur_wdata[7:0];
          endcase
        end
        3'b001: begin
          if (cur_address[1]) mem[idx][31:16] <= cur_wdata[15:0];
          else                mem[idx][15:0]  <= cur_wdata[15:0];
        end
        default: mem[idx] <= cur_wdata;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed self-checking bench for data_memory_responder (default parameters, WAIT_STATES=2).
// Expectations for the misaligned half store follow DMEM_MISALIGN_TRAP_EN when defined.
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;

  int unsigned tests = 0;
  int unsigned fails = 0;

  localparam logic [31:0] BASE = 32'h10010000;

  data_memory_responder #(
    .DATA_BASE  (32'h10010000),
    .DEPTH_WORDS(1024),
    .WAIT_STATES(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_address(req_address),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction; holds resp_ready low for 'hold' cycles after resp_valid rises.
  task automatic xact(input string tag, input logic w, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd, input int hold,
                      output logic [31:0] rd, output logic er);
    int lat;
    @(negedge clock);
    check({tag, ".req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_address = addr; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd3);
    rd = resp_rdata;
    er = resp_error;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".hold_rdata"}, resp_rdata, rd);
      check({tag, ".hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(resp_valid), 32'd0);
    check({tag, ".req_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_address = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.resp_error", 32'(resp_error), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // store then load back
    xact("sw04", 1'b1, 3'b010, BASE + 32'h4, 32'hDEADBEEF, 0, rd, er);
    check("sw04.err", 32'(er), 32'd0);
    check("sw04.rdata", rd, 32'd0);
    xact("lw04", 1'b0, 3'b010, BASE + 32'h4, 32'h0, 0, rd, er);
    check("lw04.rdata", rd, 32'hDEADBEEF);
    check("lw04.err", 32'(er), 32'd0);

    // byte store and sub-word loads
    xact("sb05", 1'b1, 3'b000, BASE + 32'h5, 32'h00000080, 0, rd, er);
    check("sb05.err", 32'(er), 32'd0);
    xact("lw04b", 1'b0, 3'b010, BASE + 32'h4, 32'h0, 0, rd, er);
    check("lw04b.rdata", rd, 32'hDEAD80EF);
    xact("lb05", 1'b0, 3'b000, BASE + 32'h5, 32'h0, 0, rd, er);
    check("lb05.rdata", rd, 32'hFFFFFF80);
    xact("lbu05", 1'b0, 3'b100, BASE + 32'h5, 32'h0, 0, rd, er);
    check("lbu05.rdata", rd, 32'h00000080);
    xact("lhu06", 1'b0, 3'b101, BASE + 32'h6, 32'h0, 0, rd, er);
    check("lhu06.rdata", rd, 32'h0000DEAD);
    xact("lh06", 1'b0, 3'b001, BASE + 32'h6, 32'h0, 0, rd, er);
    check("lh06.rdata", rd, 32'hFFFFDEAD);
    xact("lbu04", 1'b0, 3'b100, BASE + 32'h4, 32'h0, 0, rd, er);
    check("lbu04.rdata", rd, 32'h000000EF);

    // range boundaries: known values in first and last words
    xact("sw_first", 1'b1, 3'b010, BASE, 32'h11111111, 0, rd, er);
    xact("sw_last", 1'b1, 3'b010, BASE + 32'hFFC, 32'h22222222, 0, rd, er);
    check("sw_last.err", 32'(er), 32'd0);
    xact("lw_below", 1'b0, 3'b010, 32'h1000FFFC, 32'h0, 0, rd, er);
    check("lw_below.err", 32'(er), 32'd1);
    check("lw_below.rdata", rd, 32'd0);
    xact("lw_above", 1'b0, 3'b010, BASE + 32'h1000, 32'h0, 0, rd, er);
    check("lw_above.err", 32'(er), 32'd1);
    check("lw_above.rdata", rd, 32'd0);
    xact("sw_below", 1'b1, 3'b010, 32'h1000FFFC, 32'hCAFEF00D, 0, rd, er);
    check("sw_below.err", 32'(er), 32'd1);
    xact("sw_above", 1'b1, 3'b010, BASE + 32'h1000, 32'hCAFEF00D, 0, rd, er);
    check("sw_above.err", 32'(er), 32'd1);
    xact("lw_first", 1'b0, 3'b010, BASE, 32'h0, 0, rd, er);
    check("lw_first.rdata", rd, 32'h11111111);
    xact("lw_last", 1'b0, 3'b010, BASE + 32'hFFC, 32'h0, 0, rd, er);
    check("lw_last.rdata", rd, 32'h22222222);
    check("lw_last.err", 32'(er), 32'd0);

    // illegal funct3
    xact("ld011", 1'b0, 3'b011, BASE + 32'h4, 32'h0, 0, rd, er);
    check("ld011.err", 32'(er), 32'd1);
    check("ld011.rdata", rd, 32'd0);
    xact("st100", 1'b1, 3'b100, BASE + 32'h4, 32'h55555555, 0, rd, er);
    check("st100.err", 32'(er), 32'd1);
    xact("lw04c", 1'b0, 3'b010, BASE + 32'h4, 32'h0, 0, rd, er);
    check("lw04c.rdata", rd, 32'hDEAD80EF);

    // response backpressure
    xact("hold", 1'b0, 3'b010, BASE + 32'h4, 32'h0, 5, rd, er);
    check("hold.rdata", rd, 32'hDEAD80EF);

    // reset during WAIT discards the pending store
    xact("sw08", 1'b1, 3'b010, BASE + 32'h8, 32'hA5A5A5A5, 0, rd, er);
    xact("lw04d", 1'b0, 3'b010, BASE + 32'h4, 32'h0, 0, rd, er);
    check("pre_abort.rdata", resp_rdata, 32'hDEAD80EF);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_address = BASE + 32'h8; req_wdata = 32'h12345678;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("abort.in_wait", 32'(req_ready), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    check("abort.req_ready", 32'(req_ready), 32'd1);
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    check("abort.resp_rdata", resp_rdata, 32'd0);
    check("abort.resp_error", 32'(resp_error), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    xact("lw08", 1'b0, 3'b010, BASE + 32'h8, 32'h0, 0, rd, er);
    check("lw08.rdata", rd, 32'hA5A5A5A5);

    // misaligned half store
    xact("sh01", 1'b1, 3'b001, BASE + 32'h1, 32'h0000BEEF, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("sh01.err", 32'(er), 32'd1);
    xact("lw00", 1'b0, 3'b010, BASE, 32'h0, 0, rd, er);
    check("lw00.rdata", rd, 32'h11111111);
`else
    check("sh01.err", 32'(er), 32'd0);
    xact("lw00", 1'b0, 3'b010, BASE, 32'h0, 0, rd, er);
    check("lw00.rdata", rd, 32'h1111BEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
